nibble_add_sequencer: RTL and testbench
=======================================

Name: nibble_add_sequencer

Overview:
- Performs WORD_W-bit add/subtract by sequencing one shared 4-bit ripple-carry adder slice, one nibble per clock, LSB first.
- Carry is registered between nibbles.
- Uses a start/busy/done handshake.
- Sits between the microprocessor control unit and the ALU datapath, so wide arithmetic needs no wide combinational adder.

Parameters:
- WORD_W, 16, operand/result width; must be a multiple of 4 and ≥4.
- NIBBLES, WORD_W/4, derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = A+B+cin, 1 = A−B
- a  input  WORD_W  operand A
- b  input  WORD_W  operand B
- cin  input  1  carry-in for add; ignored when sub=1
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- result  output  WORD_W  sum/difference
- cout  output  1  final carry (sub: 1 = no borrow)

Behaviour:
- States: IDLE, RUN, DONE. Nibble counter cnt, width clog2(NIBBLES) (min 1).
- Reset (async, rst_n=0): state=IDLE, cnt=0, carry_q=0, a_q=b_q=0, result=0, cout=0, busy=0, done=0. Reset mid-RUN aborts the operation immediately with no done pulse.
- IDLE, start=1 at a clock edge:
  - latch a_q=a, b_q=b, sub_q=sub;
  - carry_q = sub ? 1 : cin;
  - cnt=0; go to RUN.
- RUN, each cycle, slice inputs:
  - A = a_q[4cnt+3:4cnt]
  - B = b_q nibble XOR {4{sub_q}}
  - cin0 = carry_q
- RUN, at the clock edge:
  - result nibble cnt ← slice sum; carry_q ← slice cout; cnt++.
  - At the edge where cnt==NIBBLES−1: cout ← slice cout; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge 0 → done high in the cycle after edge NIBBLES (e.g. 4-nibble word: done visible 5 cycles after start cycle); busy high for exactly NIBBLES cycles.
- result/cout during RUN are intermediate and unspecified to consumers. They hold their final value from DONE until the next accepted start.
- start while in RUN or DONE: ignored, no queuing. Operand changes after start is accepted have no effect.
- Width rules:
  - add: {cout,result} = a + b + cin (mod 2^(WORD_W+1));
  - sub: result = a − b mod 2^WORD_W, cout = (a ≥ b unsigned).
- Exactly one adder slice instance; no other adders in the block.

Optional Feature:
- Macro NIBBLE_SEQ_FLAGS_EN.
- Defined:
  - adds outputs zero (1) and ovf (1), both registered, reset 0, updated at the same edge as cout, held like result.
  - zero = (final result == 0).
  - ovf = signed overflow = carry into MSB XOR carry out of MSB, taken from the last nibble slice.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package alu_seq_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  - localparam NIBBLE_W = 4.
- One sub-module, natural and mandatory: the existing 4-bit ripple-carry adder rippercarryadder (A, B, cin0, sum, cout), instantiated once as the datapath slice.
- Nibble selection and the sub-inversion mux stay in this block.

Test Plan:
- WORD_W=16, sub=0, a=0x1234, b=0x0FCD, cin=0 → result=0x2201, cout=0; busy high 4 cycles; done one pulse 5 cycles after start.
- WORD_W=16, a=0xFFFF, b=0x0001, cin=0 → result=0x0000, cout=1 (carry ripples through all nibbles); with flags: zero=1, ovf=0.
- WORD_W=16, sub=1, a=0x0005, b=0x0007 → result=0xFFFE, cout=0 (borrow); with flags: ovf=0. Also a=0x7FFF, b=0x0001, sub=0 → 0x8000, ovf=1.
- start re-pulsed with different operands during RUN and in the DONE cycle → ignored; first operation's result unchanged; exactly one done pulse.
- rst_n low for 1 cycle during 2nd RUN cycle → all outputs 0 immediately, no done. A new start afterwards computes correctly.
- WORD_W=4 instance, a=4'b0110, b=4'b1011, cin=0 → result=4'b0001, cout=1, done 2 cycles after start.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
//   seq_state_t : sequencer FSM encoding (IDLE, RUN, DONE)
//   NIBBLE_W    : width of the shared adder slice
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Handshake/operand bundle between the control unit (master) and the
// nibble_add_sequencer (slave).
//   start, sub, a, b, cin : request side, driven by master
//   busy, done, result, cout : status/result side, driven by slave
//   zero, ovf : result flags, present only with NIBBLE_SEQ_FLAGS_EN defined
interface nibble_add_sequencer_if #(parameter int WORD_W = 16);
  logic              start;
  logic              sub;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              cin;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] result;
  logic              cout;
`ifdef NIBBLE_SEQ_FLAGS_EN
  logic              zero;
  logic              ovf;

  modport master (output start, sub, a, b, cin,
                  input  busy, done, result, cout, zero, ovf);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, result, cout, zero, ovf);
`else
  modport master (output start, sub, a, b, cin,
                  input  busy, done, result, cout);
  modport slave  (input  start, sub, a, b, cin,
                  output busy, done, result, cout);
`endif
endinterface

// File: rtl/rippercarryadder.sv
// 4-bit ripple-carry adder slice.
//   A, B : addends      cin0 : carry in
//   sum  : 4-bit sum    cout : carry out of bit 3
module rippercarryadder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin0,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin0;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign cout = c[4];
endmodule

// File: rtl/nibble_add_sequencer.sv
// WORD_W-bit add/subtract done one nibble per clock, LSB first, through a
// single shared 4-bit ripple-carry slice with the carry registered between
// nibbles.
//   clk, rst_n : clock, async active-low reset
//   bus        : nibble_add_sequencer_if.slave (start/sub/a/b/cin in,
//                busy/done/result/cout out)
// Optional: define NIBBLE_SEQ_FLAGS_EN to add registered zero/ovf flags.
module nibble_add_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_add_sequencer_if.slave  bus
);
  localparam int NIBBLES = WORD_W / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              cout_q, cout_d;
`ifdef NIBBLE_SEQ_FLAGS_EN
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              c_msb;
`endif

  logic [NIBBLE_W-1:0] a_nib, b_nib, slice_b, slice_sum;
  logic                slice_cout;

  // Nibble select by counter; B is inverted for subtract (carry_q=1 supplies
  // the +1 of two's complement).
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  assign slice_b = b_nib ^ {NIBBLE_W{sub_q}};

  rippercarryadder u_slice (
    .A    (a_nib),
    .B    (slice_b),
    .cin0 (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

`ifdef NIBBLE_SEQ_FLAGS_EN
  // Carry into bit 3 of the slice recovered from its sum bit.
  assign c_msb = slice_sum[NIBBLE_W-1] ^ a_nib[NIBBLE_W-1] ^ slice_b[NIBBLE_W-1];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef NIBBLE_SEQ_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CNT_W'(i)) result_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
        end
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = slice_cout;
`ifdef NIBBLE_SEQ_FLAGS_EN
          zero_d  = (result_d == '0);
          ovf_d   = c_msb ^ slice_cout;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef NIBBLE_SEQ_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef NIBBLE_SEQ_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef NIBBLE_SEQ_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer: a 16-bit and a 4-bit instance,
// expected results queued at request time and checked when done pulses.
module tb_nibble_add_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_add_sequencer_if #(.WORD_W(16)) b16 ();
  nibble_add_sequencer_if #(.WORD_W(4))  b4  ();

  nibble_add_sequencer #(.WORD_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  nibble_add_sequencer #(.WORD_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic c);
    exp_t e;
    logic [15:0] mask;
    logic [15:0] am, bm;
    logic [16:0] full;
    int msb;
    mask = (w == 16) ? 16'hFFFF : 16'h000F;
    msb  = w - 1;
    am   = a & mask;
    bm   = b & mask;
    if (!s) begin
      full   = {1'b0, am} + {1'b0, bm} + {16'h0, c};
      e.res  = full[15:0] & mask;
      e.cout = full[w];
      e.ovf  = (am[msb] == bm[msb]) && (e.res[msb] != am[msb]);
    end else begin
      e.res  = (am - bm) & mask;
      e.cout = (am >= bm);
      e.ovf  = (am[msb] != bm[msb]) && (e.res[msb] != am[msb]);
    end
    e.zero = (e.res == 16'h0);
    return e;
  endfunction

  task automatic drive(input bit n, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic c);
    if (n) begin
      b4.start = st; b4.a = a[3:0]; b4.b = b[3:0]; b4.sub = s; b4.cin = c;
    end else begin
      b16.start = st; b16.a = a; b16.b = b; b16.sub = s; b16.cin = c;
    end
  endtask

  task automatic sample(input bit n, output logic bsy, output logic dn, output logic co,
                        output logic [15:0] res);
    if (n) begin
      bsy = b4.busy; dn = b4.done; co = b4.cout; res = {12'h0, b4.result};
    end else begin
      bsy = b16.busy; dn = b16.done; co = b16.cout; res = b16.result;
    end
  endtask

  // Issue one operation, wait (bounded) for done, check latency, busy
  // length, result, single-cycle done and result hold.
  task automatic run_op(input bit n, input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, input bit repulse);
    int nib, bcnt, didx;
    logic bsy, dn, co;
    logic [15:0] res;
    exp_t e;
    nib  = n ? 1 : 4;
    bcnt = 0;
    didx = -1;
    @(negedge clk);
    drive(n, 1'b1, a, b, s, c);
    sb.push_back(model(n ? 4 : 16, a, b, s, c));
    @(negedge clk);
    if (repulse) drive(n, 1'b1, ~a, b ^ 16'h5A5A, ~s, ~c);
    else         drive(n, 1'b0, a, b, s, c);
    for (int k = 0; k < 20; k++) begin
      sample(n, bsy, dn, co, res);
      if (dn) begin didx = k; break; end
      if (bsy) bcnt++;
      @(negedge clk);
      if (repulse) drive(n, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(didx >= 0), 32'd1);
    if (didx >= 0) begin
      chk({tag, "_latency"}, 32'(didx), 32'(nib));
      chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(nib));
      chk({tag, "_result"}, {16'h0, res}, {16'h0, e.res});
      chk({tag, "_cout"}, {31'h0, co}, {31'h0, e.cout});
`ifdef NIBBLE_SEQ_FLAGS_EN
      chk({tag, "_zero"}, {31'h0, (n ? b4.zero : b16.zero)}, {31'h0, e.zero});
      chk({tag, "_ovf"},  {31'h0, (n ? b4.ovf  : b16.ovf)},  {31'h0, e.ovf});
`endif
      // start (if repulsed) is still high across the DONE-cycle edge
      @(negedge clk);
      drive(n, 1'b0, a, b, s, c);
      sample(n, bsy, dn, co, res);
      chk({tag, "_done_pulse"}, {31'h0, dn}, 32'd0);
      chk({tag, "_idle_after"}, {31'h0, bsy}, 32'd0);
      chk({tag, "_hold"}, {16'h0, res}, {16'h0, e.res});
    end
  endtask

  initial begin
    logic bsy, dn, co;
    logic [15:0] res;
    logic saw;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    sample(0, bsy, dn, co, res);
    chk("rst_busy",   {31'h0, bsy}, 32'd0);
    chk("rst_done",   {31'h0, dn},  32'd0);
    chk("rst_result", {16'h0, res}, 32'd0);
    chk("rst_cout",   {31'h0, co},  32'd0);
    rst_n = 1'b1;

    run_op(0, "add_basic",   16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
    run_op(0, "add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(0, "sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
    run_op(0, "add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(0, "add_cin",     16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op(0, "sub_cin_ign", 16'h0009, 16'h0003, 1'b1, 1'b1, 1'b0);
    run_op(0, "repulse",     16'hA5A5, 16'h1111, 1'b0, 1'b0, 1'b1);

    // Abort: reset for one cycle during the second RUN cycle.
    @(negedge clk);
    drive(0, 1'b1, 16'h4321, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h4321, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sample(0, bsy, dn, co, res);
    chk("abort_busy",   {31'h0, bsy}, 32'd0);
    chk("abort_done",   {31'h0, dn},  32'd0);
    chk("abort_result", {16'h0, res}, 32'd0);
    chk("abort_cout",   {31'h0, co},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sample(0, bsy, dn, co, res);
      saw = saw | dn | bsy;
    end
    chk("abort_no_done", {31'h0, saw}, 32'd0);

    run_op(0, "post_reset",  16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op(1, "narrow_add",  16'h0006, 16'h000B, 1'b0, 1'b0, 1'b0);
    run_op(1, "narrow_sub",  16'h0003, 16'h0009, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
